// File: rtl/spi_pkg.sv
// Shared types and address map for the SPI master.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_XFER  = 2'd2,
        ST_TRAIL = 2'd3
    } spi_state_e;

    localparam logic ADR_DATA = 1'b0;
    localparam logic ADR_CS   = 1'b1;

endpackage

// File: rtl/spi_master_if.sv
// Wishbone register port of the SPI master; signal names are seen from the slave side.
interface spi_master_if;
    logic        wb_spi_cyc_i;
    logic        wb_spi_stb_i;
    logic        wb_spi_we_i;
    logic        wb_spi_ack_o;
    logic        wb_spi_adr_i;
    logic [31:0] wb_spi_dat_i;
    logic [31:0] wb_spi_dat_o;

    modport master (
        output wb_spi_cyc_i, wb_spi_stb_i, wb_spi_we_i, wb_spi_adr_i, wb_spi_dat_i,
        input  wb_spi_ack_o, wb_spi_dat_o
    );

    modport slave (
        input  wb_spi_cyc_i, wb_spi_stb_i, wb_spi_we_i, wb_spi_adr_i, wb_spi_dat_i,
        output wb_spi_ack_o, wb_spi_dat_o
    );
endinterface

// File: rtl/spi_presc_cnt.sv
// Half-period timer: counts 0..H-1 while enabled and strobes tick on the wrap cycle.
module spi_presc_cnt (
    input  logic       clk_i,
    input  logic       rst_in,
    input  logic       en_i,
    input  logic [4:0] h_i,
    output logic       tick_o
);
    logic [4:0] cnt_q, cnt_d;

    assign tick_o = en_i && (cnt_q == h_i - 5'd1);

    // Reload on wrap and hold at zero while disabled so every phase starts aligned.
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || tick_o) cnt_d = '0;
        else                 cnt_d = cnt_q + 5'd1;
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/spi_master.sv
// SPI master with a two-word Wishbone port: DATA starts a 1..4 byte transfer, CS holds manual select.
module spi_master
    import spi_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_in,
    spi_master_if.slave  wb,
    input  logic [3:0]   spi_presc_i,
    input  logic         spi_cpol_i,
    input  logic         spi_cpha_i,
    input  logic         spi_auto_cs_i,
    input  logic [1:0]   spi_size_i,
    output logic         spi_rdy_o,
    output logic         spi_sck_o,
    output logic         spi_cs_on,
    output logic         spi_mosi_o,
    input  logic         spi_miso_i
);
    spi_state_e  state_q, state_d;
    logic [3:0]  presc_q, presc_d;
    logic        cpol_q, cpol_d, cpha_q, cpha_d, auto_cs_q, auto_cs_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] tx_q, tx_d, rx_sh_q, rx_sh_d, rx_q, rx_d;
    logic [4:0]  bit_q, bit_d;
    logic        half_q, half_d, sck_q, sck_d, cs_req_q, cs_req_d;

    logic        wb_req, wr_data, wr_cs, start, tick, last_half, do_sample, do_shift;
    logic [4:0]  h;

    assign h         = {1'b0, presc_q} + 5'd1;
    // Second half of the final bit: the closing boundary returns SCK to idle, no edge.
    assign last_half = half_q && (bit_q == {size_q, 3'b111});

    assign wb_req  = wb.wb_spi_cyc_i & wb.wb_spi_stb_i;
    assign wr_data = wb_req & wb.wb_spi_we_i & (wb.wb_spi_adr_i == ADR_DATA);
    assign wr_cs   = wb_req & wb.wb_spi_we_i & (wb.wb_spi_adr_i == ADR_CS);
    assign start   = wr_data & (state_q == ST_IDLE);

    // A data write while busy is stalled until the engine is back in IDLE.
    assign wb.wb_spi_ack_o = wb_req & ~(wr_data & (state_q != ST_IDLE));
    assign wb.wb_spi_dat_o = (wb.wb_spi_adr_i == ADR_CS) ? {31'b0, cs_req_q} : rx_q;

    assign spi_rdy_o  = (state_q == ST_IDLE);
    // Idle SCK follows the live CPOL input but is forced low while reset is held.
    assign spi_sck_o  = spi_rdy_o ? (spi_cpol_i & rst_in) : sck_q;
    // TX data is left-aligned at load, so bit 31 is always the bit on the wire.
    assign spi_mosi_o = ~spi_rdy_o & tx_q[31];
    assign spi_cs_on  = (~spi_rdy_o & auto_cs_q) ? 1'b0 : ~cs_req_q;

    spi_presc_cnt u_presc (
        .clk_i  (clk_i),
        .rst_in (rst_in),
        .en_i   (~spi_rdy_o),
        .h_i    (h),
        .tick_o (tick)
    );

    // Next-state, SCK, shift and register-write logic.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        auto_cs_d = auto_cs_q;
        size_d    = size_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_d      = rx_q;
        bit_d     = bit_q;
        half_d    = half_q;
        sck_d     = sck_q;
        cs_req_d  = cs_req_q;
        do_sample = 1'b0;
        do_shift  = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                state_d   = ST_LEAD;
                presc_d   = spi_presc_i;
                cpol_d    = spi_cpol_i;
                cpha_d    = spi_cpha_i;
                auto_cs_d = spi_auto_cs_i;
                size_d    = spi_size_i;
                tx_d      = wb.wb_spi_dat_i << {~spi_size_i, 3'b000};
                rx_sh_d   = '0;
                bit_d     = '0;
                half_d    = 1'b0;
                sck_d     = spi_cpol_i;
            end
            // LEAD tick is the first leading edge; with CPHA=1 the MSB is already out.
            ST_LEAD: if (tick) begin
                state_d   = ST_XFER;
                sck_d     = ~cpol_q;
                do_sample = ~cpha_q;
            end
            // half_q=0 ends on a trailing edge, half_q=1 on a leading edge.
            ST_XFER: if (tick) begin
                if (last_half) begin
                    state_d = ST_TRAIL;
                    sck_d   = cpol_q;
                end else begin
                    sck_d     = ~sck_q;
                    half_d    = ~half_q;
                    if (half_q) bit_d = bit_q + 5'd1;
                    do_sample = half_q ^ cpha_q;
                    do_shift  = ~(half_q ^ cpha_q);
                end
            end
            ST_TRAIL: if (tick) begin
                state_d = ST_IDLE;
                rx_d    = rx_sh_q;
            end
            default: state_d = ST_IDLE;
        endcase
        if (do_sample) rx_sh_d = {rx_sh_q[30:0], spi_miso_i};
        if (do_shift)  tx_d    = {tx_q[30:0], 1'b0};
        if (wr_cs)     cs_req_d = wb.wb_spi_dat_i[0];
    end

    // State and datapath registers; reset aborts any transfer immediately.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            auto_cs_q <= 1'b0;
            size_q    <= '0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_q      <= '0;
            bit_q     <= '0;
            half_q    <= 1'b0;
            sck_q     <= 1'b0;
            cs_req_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            auto_cs_q <= auto_cs_d;
            size_q    <= size_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_q      <= rx_d;
            bit_q     <= bit_d;
            half_q    <= half_d;
            sck_q     <= sck_d;
            cs_req_q  <= cs_req_d;
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: stimulus queues expectations, a negedge monitor checks the wire and bus.
module tb_spi_master;
    import spi_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_in = 1'b0;
    logic [3:0] spi_presc_i = '0;
    logic       spi_cpol_i = 1'b1;
    logic       spi_cpha_i = 1'b0;
    logic       spi_auto_cs_i = 1'b1;
    logic [1:0] spi_size_i = '0;
    logic       spi_rdy_o, spi_sck_o, spi_cs_on, spi_mosi_o, spi_miso_i;
    logic       miso_tie1 = 1'b0;

    spi_master_if wb_if ();

    spi_master dut (
        .clk_i         (clk_i),
        .rst_in        (rst_in),
        .wb            (wb_if),
        .spi_presc_i   (spi_presc_i),
        .spi_cpol_i    (spi_cpol_i),
        .spi_cpha_i    (spi_cpha_i),
        .spi_auto_cs_i (spi_auto_cs_i),
        .spi_size_i    (spi_size_i),
        .spi_rdy_o     (spi_rdy_o),
        .spi_sck_o     (spi_sck_o),
        .spi_cs_on     (spi_cs_on),
        .spi_mosi_o    (spi_mosi_o),
        .spi_miso_i    (spi_miso_i)
    );

    assign spi_miso_i = miso_tie1 ? 1'b1 : spi_mosi_o;

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] data;
        logic        cpol;
        logic        cpha;
        logic        auto_cs;
        int          n;
        int          h;
    } xfer_t;

    xfer_t       exp_q[$];
    logic [31:0] rd_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        cs_req_exp = 1'b0;
    logic [31:0] rx_model = '0;
    logic [31:0] pend_rx = '0;
    bit          have_pend = 1'b0;

    function automatic logic [31:0] mask_of(int n);
        logic [31:0] one;
        one = 32'h1;
        return (n >= 4) ? 32'hFFFF_FFFF : ((one << (8 * n)) - 32'h1);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic wb_write(logic adr, logic [31:0] dat);
        bit acked;
        acked = 1'b0;
        @(posedge clk_i); #1;
        wb_if.wb_spi_cyc_i = 1'b1;
        wb_if.wb_spi_stb_i = 1'b1;
        wb_if.wb_spi_we_i  = 1'b1;
        wb_if.wb_spi_adr_i = adr;
        wb_if.wb_spi_dat_i = dat;
        for (int w = 0; w < 3000 && !acked; w++) begin
            @(negedge clk_i);
            acked = wb_if.wb_spi_ack_o;
        end
        check("write_ack_timeout", {31'b0, acked}, 32'h1);
        @(posedge clk_i); #1;
        wb_if.wb_spi_cyc_i = 1'b0;
        wb_if.wb_spi_stb_i = 1'b0;
        wb_if.wb_spi_we_i  = 1'b0;
        if (adr == ADR_CS) cs_req_exp = dat[0];
    endtask

    task automatic wb_read(logic adr, logic [31:0] expv);
        rd_q.push_back(expv);
        @(posedge clk_i); #1;
        wb_if.wb_spi_cyc_i = 1'b1;
        wb_if.wb_spi_stb_i = 1'b1;
        wb_if.wb_spi_we_i  = 1'b0;
        wb_if.wb_spi_adr_i = adr;
        @(posedge clk_i); #1;
        wb_if.wb_spi_cyc_i = 1'b0;
        wb_if.wb_spi_stb_i = 1'b0;
    endtask

    // Queue the expected transfer from the current config inputs and issue the data write.
    task automatic start_xfer(logic [31:0] d);
        xfer_t       e;
        logic [31:0] nrx;
        e.data    = d;
        e.cpol    = spi_cpol_i;
        e.cpha    = spi_cpha_i;
        e.auto_cs = spi_auto_cs_i;
        e.n       = int'(spi_size_i) + 1;
        e.h       = int'(spi_presc_i) + 1;
        nrx = miso_tie1 ? mask_of(e.n) : (d & mask_of(e.n));
        exp_q.push_back(e);
        wb_write(ADR_DATA, d);
        if (have_pend) rx_model = pend_rx;
        pend_rx   = nrx;
        have_pend = 1'b1;
    endtask

    task automatic wait_idle();
        for (int w = 0; w < 2000 && !spi_rdy_o; w++) @(negedge clk_i);
        check("idle_timeout", {31'b0, spi_rdy_o}, 32'h1);
        if (have_pend) rx_model = pend_rx;
        have_pend = 1'b0;
    endtask

    task automatic set_cfg(logic pol, logic pha, logic [3:0] pr, logic [1:0] sz, logic ac);
        spi_cpol_i    = pol;
        spi_cpha_i    = pha;
        spi_presc_i   = pr;
        spi_size_i    = sz;
        spi_auto_cs_i = ac;
    endtask

    // Monitor state
    xfer_t       cur;
    bit          in_xfer = 1'b0;
    bit          expect_start = 1'b0;
    int          busy, last_t, edges, iv_bad;
    logic        prev_sck;
    logic [31:0] cap;

    // Monitor: bus handshake, read data, SPI wire behaviour and per-transfer totals.
    always @(negedge clk_i) begin
        if (!rst_in) begin
            in_xfer      = 1'b0;
            expect_start = 1'b0;
        end else begin
            if (expect_start) check("start_on_ack", {31'b0, spi_rdy_o}, 32'h0);
            expect_start = 1'b0;
            if (wb_if.wb_spi_cyc_i && wb_if.wb_spi_stb_i) begin
                if (wb_if.wb_spi_we_i && wb_if.wb_spi_adr_i == ADR_DATA && !spi_rdy_o)
                    check("ack_hold_busy", {31'b0, wb_if.wb_spi_ack_o}, 32'h0);
                else
                    check("ack", {31'b0, wb_if.wb_spi_ack_o}, 32'h1);
                if (wb_if.wb_spi_we_i && wb_if.wb_spi_adr_i == ADR_DATA && wb_if.wb_spi_ack_o)
                    expect_start = 1'b1;
                if (!wb_if.wb_spi_we_i && wb_if.wb_spi_ack_o) begin
                    if (rd_q.size() == 0) check("unexpected_read", 32'h1, 32'h0);
                    else check("read_data", wb_if.wb_spi_dat_o, rd_q.pop_front());
                end
            end
            if (!spi_rdy_o) begin
                if (!in_xfer) begin
                    in_xfer = 1'b1;
                    if (exp_q.size() == 0) begin
                        check("unexpected_xfer", 32'h1, 32'h0);
                        cur = '{32'h0, 1'b0, 1'b0, 1'b0, 1, 1};
                    end else begin
                        cur = exp_q[0];
                    end
                    busy = 0; last_t = 1; edges = 0; iv_bad = 0; cap = '0;
                    prev_sck = cur.cpol;
                end
                busy++;
                if (spi_sck_o !== prev_sck) begin
                    edges++;
                    if (busy - last_t != cur.h) iv_bad++;
                    last_t = busy;
                    if ((spi_sck_o != cur.cpol) != cur.cpha) cap = {cap[30:0], spi_mosi_o};
                    prev_sck = spi_sck_o;
                end
                check("cs_busy", {31'b0, spi_cs_on}, {31'b0, cur.auto_cs ? 1'b0 : ~cs_req_exp});
            end else begin
                if (in_xfer) begin
                    in_xfer = 1'b0;
                    check("busy_cycles", busy, cur.h * (16 * cur.n + 2));
                    check("sck_edges", edges, 16 * cur.n);
                    check("half_period_err", iv_bad, 0);
                    check("mosi_word", cap, cur.data & mask_of(cur.n));
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                check("sck_idle", {31'b0, spi_sck_o}, {31'b0, spi_cpol_i});
                check("mosi_idle", {31'b0, spi_mosi_o}, 32'h0);
                check("cs_idle", {31'b0, spi_cs_on}, {31'b0, ~cs_req_exp});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        wb_if.wb_spi_cyc_i = 1'b0;
        wb_if.wb_spi_stb_i = 1'b0;
        wb_if.wb_spi_we_i  = 1'b0;
        wb_if.wb_spi_adr_i = 1'b0;
        wb_if.wb_spi_dat_i = '0;

        // Reset state with CPOL=1 so a forced-low SCK is distinguishable.
        #12;
        check("rst_rdy", {31'b0, spi_rdy_o}, 32'h1);
        check("rst_cs", {31'b0, spi_cs_on}, 32'h1);
        check("rst_sck", {31'b0, spi_sck_o}, 32'h0);
        check("rst_mosi", {31'b0, spi_mosi_o}, 32'h0);
        #11 rst_in = 1'b1;
        wb_read(ADR_DATA, 32'h0);
        wb_read(ADR_CS, 32'h0);

        // Mode 0, fastest clock, one byte, loopback.
        set_cfg(1'b0, 1'b0, 4'd0, 2'd0, 1'b1);
        miso_tie1 = 1'b0;
        start_xfer(32'h0000_00A5);
        wait_idle();
        wb_read(ADR_DATA, 32'h0000_00A5);

        // Mode 3, presc 3, four bytes, MISO tied high.
        set_cfg(1'b1, 1'b1, 4'd3, 2'd3, 1'b1);
        miso_tie1 = 1'b1;
        start_xfer(32'h1234_5678);
        wait_idle();
        wb_read(ADR_DATA, 32'hFFFF_FFFF);

        // Back-to-back data writes: second is stalled, then starts on its ack edge.
        miso_tie1 = 1'b0;
        set_cfg(1'b0, 1'b0, 4'd1, 2'd1, 1'b1);
        start_xfer(32'hDEAD_BEEF);
        set_cfg(1'b1, 1'b1, 4'd0, 2'd0, 1'b1);
        start_xfer(32'h0000_003C);
        wb_read(ADR_DATA, 32'h0000_BEEF);
        wait_idle();
        wb_read(ADR_DATA, 32'h0000_003C);

        // Manual chip select around a two-byte transfer.
        set_cfg(1'b0, 1'b1, 4'd2, 2'd1, 1'b0);
        wb_write(ADR_CS, 32'h1);
        wb_read(ADR_CS, 32'h1);
        start_xfer(32'h0000_C3A1);
        wait_idle();
        repeat (3) @(posedge clk_i);
        wb_write(ADR_CS, 32'h0);
        wb_read(ADR_CS, 32'h0);
        wb_read(ADR_DATA, 32'h0000_C3A1);

        // Random transfers; config inputs are scrambled while each is in flight.
        for (int i = 0; i < 10; i++) begin
            set_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            miso_tie1 = 1'($urandom_range(0, 1));
            d = $urandom;
            start_xfer(d);
            wb_read(ADR_DATA, rx_model);
            repeat (3) @(posedge clk_i);
            #1;
            set_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                    2'($urandom), 1'($urandom_range(0, 1)));
            wait_idle();
            wb_read(ADR_DATA, rx_model);
        end

        // Asynchronous reset in the middle of a transfer.
        miso_tie1 = 1'b0;
        set_cfg(1'b1, 1'b0, 4'd1, 2'd3, 1'b1);
        wb_write(ADR_CS, 32'h1);
        start_xfer(32'hCAFE_F00D);
        repeat (10) @(posedge clk_i);
        #3 rst_in = 1'b0;
        #1;
        check("abort_cs", {31'b0, spi_cs_on}, 32'h1);
        check("abort_sck", {31'b0, spi_sck_o}, 32'h0);
        check("abort_mosi", {31'b0, spi_mosi_o}, 32'h0);
        check("abort_rdy", {31'b0, spi_rdy_o}, 32'h1);
        exp_q.delete();
        have_pend  = 1'b0;
        rx_model   = '0;
        cs_req_exp = 1'b0;
        repeat (3) @(negedge clk_i);
        #2 rst_in = 1'b1;
        @(negedge clk_i);
        check("post_rst_rdy", {31'b0, spi_rdy_o}, 32'h1);
        wb_read(ADR_DATA, 32'h0);
        wb_read(ADR_CS, 32'h0);
        set_cfg(1'b0, 1'b1, 4'd0, 2'd2, 1'b1);
        start_xfer(32'h0055_AA11);
        wait_idle();
        wb_read(ADR_DATA, 32'h0055_AA11);

        repeat (4) @(posedge clk_i);
        check("exp_q_drained", exp_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
